mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  MIPS MEM-stage load/store unit: byte-addressed data RAM with byte/half/word
//  accesses, load sign/zero extension, misalignment detection and a read-only
//  debug port for the debug unit's memory dump. A power-up clear FSM zeroes the
//  RAM after every reset. Sits between EX/MEM and MEM/WB pipeline registers.
// PARAMETERS
//  LEN      32    data width in bits (fixed 32 for MIPS; byte lanes = LEN/8)
//  DEPTH    2048  number of LEN-bit words
//  NB_ADDR  $clog2(DEPTH)  word-index width (derived, do not override)
// PORTS
//  i_clk          in   1        clock
//  i_rst          in   1        synchronous active-high reset
//  i_address      in   LEN      byte address from ALU
//  i_write_data   in   LEN      store data (rt), right-aligned
//  i_mem_read     in   1        load request
//  i_mem_write    in   1        store request
//  i_size         in   2        00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  i_unsigned     in   1        1 = zero-extend load (LBU/LHU), 0 = sign-extend
//  i_dbg_addr     in   NB_ADDR  debug word index
//  o_read_data    out  LEN      extended load result, 1-cycle latency
//  o_misaligned   out  1        access in previous cycle was misaligned
//  o_busy         out  1        clear sweep in progress; stall pipeline
//  o_dbg_data     out  LEN      word at i_dbg_addr, 1-cycle latency
// BEHAVIOUR
//  Reset: i_rst sampled high -> o_read_data=0, o_misaligned=0, o_dbg_data=0,
//   o_busy=1, FSM=CLEAR, sweep counter=0. Reset during CLEAR restarts at word 0.
//  FSM: CLEAR -> writes 0 to word[cnt] each cycle, cnt++; after word DEPTH-1
//   written -> IDLE next cycle (o_busy low exactly DEPTH cycles after reset
//   deasserts). IDLE -> stays until i_rst. In CLEAR all loads/stores ignored,
//   o_read_data held 0, o_misaligned held 0.
//  Addressing: word index = i_address[NB_ADDR+1:2]; upper bits ignored (wrap
//   modulo DEPTH*4 bytes). Lane = i_address[1:0], little-endian (lane 0 = [7:0]).
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Misaligned store is
//   suppressed (no byte written); misaligned load returns o_read_data=0. Both
//   raise o_misaligned for one cycle, aligned with the would-be data.
//  Store: byte -> write i_write_data[7:0] to lane addr[1:0]; half -> [15:0] to
//   lanes {addr[1],0}..+1; word -> all lanes. Per-byte write enables; other
//   lanes unchanged. Write takes effect at the clock edge.
//  Load: registered; data of cycle N visible on o_read_data in cycle N+1. Select
//   lane(s), extend per i_unsigned to LEN. No request -> o_read_data holds.
//  Read+write same cycle (i_mem_read & i_mem_write): store performed, load
//   returns pre-store contents (read-first). Not produced by the decoder;
//   defined for determinism only.
//  Debug port: independent read port, always active including CLEAR (returns
//   contents as swept), read-first vs concurrent store, 1-cycle latency.
//  Storage must infer block RAM: one R/W port with byte enables + one read port.
// TESTING
//  1 Reset 1 cycle then idle -> o_busy high DEPTH cycles, drops; dbg read of
//    words 0, 1, DEPTH-1 -> 0x00000000.
//  2 SW 0x8899AABB @0x10; LW @0x10 -> 0x8899AABB next cycle; LB @0x10 ->
//    0xFFFFFFBB; LBU @0x13 -> 0x00000088; LH @0x12 -> 0xFFFF8899; LHU @0x10 -> 0x0000AABB.
//  3 SW 0 @0x20; SB 0x7F @0x21; SH 0x1234 @0x22 -> LW @0x20 = 0x12347F00.
//  4 SW 0xDEADBEEF @0x0; SW 0x1 @0x2 (misaligned) -> o_misaligned=1, word 0
//    still 0xDEADBEEF; LH @0x3 -> o_read_data=0, o_misaligned=1.
//  5 SW 0xCAFEF00D @(DEPTH*4+0x8) -> LW @0x8 = 0xCAFEF00D (wrap); dbg_addr=2
//    -> 0xCAFEF00D.
//  6 Write data, assert i_rst mid-sweep (cycle DEPTH/2) -> o_busy stays high
//    another DEPTH cycles; all words read 0; SW/LW issued while busy have no
//    effect and o_read_data=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte-addressed data RAM with byte/half/word
// accesses, load extension, misalignment flagging and a debug read port.
module mem_stage_lsu #(
    parameter  int LEN     = 32,
    parameter  int DEPTH   = 2048,
    localparam int NB_ADDR = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [LEN-1:0]     i_address,
    input  logic [LEN-1:0]     i_write_data,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [LEN-1:0]     o_read_data,
    output logic               o_misaligned,
    output logic               o_busy,
    output logic [LEN-1:0]     o_dbg_data
);

    localparam int NB = LEN / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [NB_ADDR-1:0] cnt, cnt_nxt;

    logic [LEN-1:0] mem [DEPTH];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         lane;
    logic               acc_en;
    logic               mis;
    logic               st_en;
    logic               ld_en;

    logic [NB_ADDR-1:0] a_addr;
    logic [NB-1:0]      a_be;
    logic [NB-1:0]      st_be;
    logic [LEN-1:0]     a_wdata;
    logic [LEN-1:0]     st_wdata;

    logic [LEN-1:0] rd_raw;
    logic [LEN-1:0] dbg_raw;
    logic           dbg_vld;
    logic           ld_q;
    logic           mis_q;
    logic [1:0]     lane_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [LEN-1:0] hold_q;
    logic [LEN-1:0] ext;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;

    // Upper address bits wrap: they do not take part in addressing.
    logic unused_addr;
    assign unused_addr = ^i_address[LEN-1:NB_ADDR+2];

    assign word_idx = i_address[NB_ADDR+1:2];
    assign lane     = i_address[1:0];

    // State register for the power-up clear sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep sequencing: one word per cycle, then idle until the next reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        o_busy    = 1'b0;
        case (state)
            CLEAR: begin
                o_busy  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == NB_ADDR'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Classify the request: misalignment, byte enables and lane-replicated data.
    always_comb begin
        acc_en   = (state == IDLE) && !i_rst;
        mis      = 1'b0;
        st_be    = '0;
        st_wdata = i_write_data;
        if (i_size == 2'b00) begin
            st_be    = NB'(1) << lane;
            st_wdata = {NB{i_write_data[7:0]}};
        end else if (i_size == 2'b01) begin
            mis      = lane[0];
            st_be    = lane[1] ? 4'b1100 : 4'b0011;
            st_wdata = {(NB/2){i_write_data[15:0]}};
        end else begin
            mis      = (lane != 2'b00);
            st_be    = '1;
        end
        st_en = acc_en && i_mem_write && !mis;
        ld_en = acc_en && i_mem_read;
    end

    // The sweep owns the R/W port while clearing.
    always_comb begin
        a_addr  = word_idx;
        a_be    = st_en ? st_be : '0;
        a_wdata = st_wdata;
        if (state == CLEAR) begin
            a_addr  = cnt;
            a_be    = '1;
            a_wdata = '0;
        end
    end

    // Main RAM port: read-first with per-byte write enables.
    always_ff @(posedge i_clk) begin
        if (ld_en) begin
            rd_raw <= mem[a_addr];
        end
        for (int b = 0; b < NB; b++) begin
            if (a_be[b]) begin
                mem[a_addr][8*b +: 8] <= a_wdata[8*b +: 8];
            end
        end
    end

    // Debug port: independent read-only access.
    always_ff @(posedge i_clk) begin
        dbg_raw <= mem[i_dbg_addr];
    end

    // Load bookkeeping aligned with the RAM output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ld_q    <= 1'b0;
            mis_q   <= 1'b0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            hold_q  <= '0;
            dbg_vld <= 1'b0;
        end else begin
            ld_q    <= ld_en;
            mis_q   <= acc_en && (i_mem_read || i_mem_write) && mis;
            dbg_vld <= 1'b1;
            if (ld_en) begin
                lane_q <= lane;
                size_q <= i_size;
                uns_q  <= i_unsigned;
            end
            if (ld_q) begin
                hold_q <= ext;
            end
        end
    end

    // Lane selection and sign/zero extension of the raw word.
    always_comb begin
        ld_byte = rd_raw[8*lane_q +: 8];
        ld_half = rd_raw[16*lane_q[1] +: 16];
        ext     = rd_raw;
        if (size_q == 2'b00) begin
            ext = {{(LEN-8){!uns_q && ld_byte[7]}}, ld_byte};
        end else if (size_q == 2'b01) begin
            ext = {{(LEN-16){!uns_q && ld_half[15]}}, ld_half};
        end
        if (mis_q) begin
            ext = '0;
        end
    end

    assign o_read_data  = ld_q ? ext : hold_q;
    assign o_misaligned = mis_q;
    assign o_dbg_data   = dbg_vld ? dbg_raw : '0;

endmodule
